otter_fetch_unit: RTL
=====================

OTTER_FETCH_UNIT -- requirements
Module: otter_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port CLK  input  1  rising-edge clock.
REQ-003 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port imem_req  output  1  single-cycle fetch request pulse.
REQ-005 SHALL have port imem_addr  output  32  fetch address; valid when imem_req=1.
REQ-006 SHALL have port imem_rvalid  input  1  response strobe for the outstanding request.
REQ-007 SHALL have port imem_rdata  input  32  instruction word; valid when imem_rvalid=1.
REQ-008 SHALL have port if_valid  output  1  FIFO head holds an instruction for the decode (FD) register.
REQ-009 SHALL have port if_ir  output  32  head instruction.
REQ-010 SHALL have port if_pc  output  32  head instruction address.
REQ-011 SHALL have port if_pc_inc  output  32  if_pc+4 (modulo 2^32).
REQ-012 SHALL have port stall_F  input  1  decode not accepting; holds head.
REQ-013 SHALL have port redirect  input  1  branch/jump taken; flush and refetch.
REQ-014 SHALL have port redirect_pc  input  32  new fetch address; bits [1:0] treated as 0.

Function
REQ-015 SHALL keep a fetch_pc register; imem_addr SHALL equal fetch_pc combinationally.
REQ-016 SHALL keep a 2-entry FIFO of {pc, ir}; count 0..2.
REQ-017 SHALL implement FSM states IDLE (none outstanding), WAIT (one outstanding, response kept), DISCARD (one outstanding, response dropped).
REQ-018 SHALL define pop = if_valid & ~stall_F & ~redirect; pop removes the head at the clock edge.
REQ-019 SHALL assert imem_req when ~redirect & (IDLE | (WAIT & imem_rvalid)) & (count + (WAIT?1:0) - pop) < 2.
REQ-020 SHALL increment fetch_pc by 4 on every cycle imem_req=1; the next state SHALL be WAIT.
REQ-021 In WAIT with imem_rvalid=1, SHALL push {pc of that request, imem_rdata}; if no new request, next state SHALL be IDLE.
REQ-022 SHALL allow push and pop in the same cycle; the FIFO SHALL never overflow, which REQ-019 guarantees.
REQ-023 SHALL drive if_valid = (count>0) and if_ir/if_pc from the head; when count=0, if_ir and if_pc SHALL be 0.
REQ-024 On redirect=1, SHALL clear the FIFO and load fetch_pc <= {redirect_pc[31:2],2'b00}; no request SHALL issue in that cycle.
REQ-025 On redirect in WAIT without imem_rvalid, next state SHALL be DISCARD; with imem_rvalid, the response SHALL be dropped and next state SHALL be IDLE.
REQ-026 In DISCARD, imem_rvalid SHALL be dropped and next state SHALL be IDLE; a further redirect SHALL update fetch_pc and keep the state DISCARD unless imem_rvalid=1.
REQ-027 SHALL give redirect priority over stall_F.
REQ-028 SHALL ignore imem_rvalid in IDLE.
REQ-029 With 1-cycle memory and no stall, SHALL sustain one if_valid instruction per cycle; first if_valid SHALL occur 2 cycles after the first imem_req.

Reset
REQ-030 While RST=1, SHALL force state IDLE, count 0, fetch_pc RESET_PC, imem_req 0, if_valid 0, if_ir 0, if_pc 0, if_pc_inc 4.
REQ-031 Reset mid-operation SHALL abandon any outstanding request; the first imem_rvalid after reset release, if in IDLE, SHALL be ignored.
REQ-032 The first imem_req SHALL occur in the first clock cycle after RST deasserts, with imem_addr = RESET_PC.

Verification
REQ-033 Reset release, 1-cycle memory returning addr as data -> imem_addr 0,4,8 on consecutive cycles; if_pc 0,4,8 and if_ir equal to if_pc from cycle 2.
REQ-034 stall_F=1 for 5 cycles with the FIFO filling -> count reaches 2, imem_req stays 0, if_pc held; after release, order is preserved with no loss or duplication.
REQ-035 3-cycle memory latency -> exactly one outstanding request; one instruction per 3 cycles.
REQ-036 redirect to 0x100 while WAIT -> FIFO empties; next imem_rvalid is dropped; the next request has address 0x100; the next if_pc is 0x100.
REQ-037 redirect with redirect_pc=0x203 in the same cycle as imem_rvalid -> data dropped; next request address 0x200; state IDLE->WAIT.
REQ-038 RST pulse during WAIT, then a stray imem_rvalid -> ignored; if_valid 0 until the response to RESET_PC arrives.

Source files
------------

// File: rtl/otter_fetch_unit.sv
// otter_fetch_unit
//   Instruction fetch front end: issues single-cycle fetch requests to the
//   instruction memory and queues returned instructions in a 2-entry FIFO
//   feeding the decode (FD) register. At most one request is outstanding.
//
// Ports
//   CLK, RST        clock (rising edge), asynchronous active-high reset
//   imem_req/addr   fetch request pulse and its address (addr = fetch_pc)
//   imem_rvalid/rdata  response strobe and instruction word
//   if_valid        FIFO head holds an instruction
//   if_ir/if_pc     head instruction and its address (0 when empty)
//   if_pc_inc       if_pc + 4
//   stall_F         decode not accepting; head is held
//   redirect/redirect_pc  flush and refetch from redirect_pc (word aligned)
module otter_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RST,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_ir,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_inc,
   input  logic        stall_F,
   input  logic        redirect,
   input  logic [31:0] redirect_pc
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      DISCARD = 2'd2
   } state_t;

   state_t      r_state, w_next_state;
   logic [31:0] r_fetch_pc;
   logic [31:0] r_req_pc;
   logic [1:0]  r_cnt;
   logic [31:0] r_pc0, r_ir0, r_pc1, r_ir1;

   logic        w_valid;
   logic        w_pop;
   logic        w_push;
   logic        w_req;
   logic        w_wait;
   logic [2:0]  w_occ;

   assign w_valid = (r_cnt != 2'd0);
   assign w_pop   = w_valid & ~stall_F & ~redirect;
   assign w_wait  = (r_state == WAIT);
   assign w_push  = w_wait & imem_rvalid & ~redirect;

   // Occupancy once the outstanding response (if any) lands and the pop
   // takes effect; a new request is only allowed if its response fits.
   assign w_occ = {1'b0, r_cnt} + {2'b00, w_wait} - {2'b00, w_pop};
   assign w_req = ~RST & ~redirect
                & ((r_state == IDLE) | (w_wait & imem_rvalid))
                & (w_occ < 3'd2);

   // State register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= IDLE;
      else     r_state <= w_next_state;
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         IDLE:    w_next_state = w_req ? WAIT : IDLE;
         WAIT: begin
            if (redirect)         w_next_state = imem_rvalid ? IDLE : DISCARD;
            else if (imem_rvalid) w_next_state = w_req ? WAIT : IDLE;
            else                  w_next_state = WAIT;
         end
         DISCARD: w_next_state = imem_rvalid ? IDLE : DISCARD;
         default: w_next_state = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      imem_req  = w_req;
      imem_addr = r_fetch_pc;
      if_valid  = w_valid;
      if_ir     = w_valid ? r_ir0 : '0;
      if_pc     = w_valid ? r_pc0 : '0;
      if_pc_inc = if_pc + 32'd4;
   end

   // Fetch PC and the PC of the outstanding request
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_fetch_pc <= RESET_PC;
         r_req_pc   <= '0;
      end else if (redirect) begin
         r_fetch_pc <= {redirect_pc[31:2], 2'b00};
      end else if (w_req) begin
         r_fetch_pc <= r_fetch_pc + 32'd4;
         r_req_pc   <= r_fetch_pc;
      end
   end

   // 2-entry FIFO, head in entry 0; a pop shifts entry 1 down.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_cnt <= 2'd0;
         r_pc0 <= '0;
         r_ir0 <= '0;
         r_pc1 <= '0;
         r_ir1 <= '0;
      end else if (redirect) begin
         r_cnt <= 2'd0;
      end else begin
         unique case ({w_push, w_pop})
            2'b10: begin
               if (r_cnt == 2'd0) begin
                  r_pc0 <= r_req_pc;
                  r_ir0 <= imem_rdata;
               end else begin
                  r_pc1 <= r_req_pc;
                  r_ir1 <= imem_rdata;
               end
               r_cnt <= r_cnt + 2'd1;
            end
            2'b01: begin
               r_pc0 <= r_pc1;
               r_ir0 <= r_ir1;
               r_cnt <= r_cnt - 2'd1;
            end
            2'b11: begin
               if (r_cnt == 2'd1) begin
                  r_pc0 <= r_req_pc;
                  r_ir0 <= imem_rdata;
               end else begin
                  r_pc0 <= r_pc1;
                  r_ir0 <= r_ir1;
                  r_pc1 <= r_req_pc;
                  r_ir1 <= imem_rdata;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
